// File: rtl/ddr_pkg.sv
// Shared types and default constants for the DDR lane judge.
package ddr_pkg;

  typedef enum logic [1:0] {
    GRADE_NONE,
    GRADE_PERFECT,
    GRADE_GOOD,
    GRADE_MISS
  } grade_t;

  typedef enum logic [1:0] {
    J_IDLE,
    J_OPEN,
    J_CLOSED
  } judge_state_t;

  // Judge FSM encodings used on plain logic state vectors
  localparam logic [1:0] ST_IDLE   = 2'(J_IDLE);
  localparam logic [1:0] ST_OPEN   = 2'(J_OPEN);
  localparam logic [1:0] ST_CLOSED = 2'(J_CLOSED);

  localparam int unsigned DEF_LANES         = 4;
  localparam int unsigned DEF_TICK_W        = 16;
  localparam int unsigned DEF_PERFECT_TICKS = 8;
  localparam int unsigned DEF_GOOD_TICKS    = 20;
  localparam int unsigned DEF_PERFECT_PTS   = 3;
  localparam int unsigned DEF_GOOD_PTS      = 1;
  localparam int unsigned DEF_SCORE_W       = 32;
  localparam int unsigned DEF_COMBO_W       = 8;
  localparam int unsigned DEF_LED_HOLD      = 1000;
  localparam int unsigned DEF_BONUS_COMBO   = 10;

endpackage

// File: rtl/ddr_lane_judge_lane_grader.sv
// Per-lane press edge detection, pending-target tracking and grade decision.
module lane_grader
  import ddr_pkg::*;
#(
  parameter int unsigned TICK_W        = DEF_TICK_W,
  parameter int unsigned PERFECT_TICKS = DEF_PERFECT_TICKS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              beat_pulse,
  input  logic              close,
  input  logic [1:0]        state,
  input  logic [TICK_W-1:0] tick_cnt,
  input  logic              target,
  input  logic              button,
  output grade_t            grade_c
);

  logic btn_q;
  logic pending;
  logic rise;

  assign rise = button & ~btn_q;

  // Grade a press against the current window, or a target left unpressed
  always_comb begin
    grade_c = GRADE_NONE;
    if ((state != ST_IDLE) && rise) begin
      if (pending) begin
        grade_c = (tick_cnt <= TICK_W'(PERFECT_TICKS)) ? GRADE_PERFECT : GRADE_GOOD;
      end else begin
        grade_c = GRADE_MISS;
      end
    end else if (pending && (beat_pulse || close)) begin
      grade_c = GRADE_MISS;
    end
  end

  // Button history and pending target; a new beat reloads the target
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      btn_q <= button;
      if (beat_pulse) begin
        pending <= target;
      end else if (rise || close) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ddr_lane_judge.sv
// Multi-lane step judge: window FSM, score/combo accumulation, feedback LEDs.
// Optional macro DDR_COMBO_BONUS_EN doubles hit points once combo >= BONUS_COMBO.
module ddr_lane_judge
  import ddr_pkg::*;
#(
  parameter int unsigned LANES         = DEF_LANES,
  parameter int unsigned TICK_W        = DEF_TICK_W,
  parameter int unsigned PERFECT_TICKS = DEF_PERFECT_TICKS,
  parameter int unsigned GOOD_TICKS    = DEF_GOOD_TICKS,
  parameter int unsigned PERFECT_PTS   = DEF_PERFECT_PTS,
  parameter int unsigned GOOD_PTS      = DEF_GOOD_PTS,
  parameter int unsigned SCORE_W       = DEF_SCORE_W,
  parameter int unsigned COMBO_W       = DEF_COMBO_W,
  parameter int unsigned LED_HOLD      = DEF_LED_HOLD,
  parameter int unsigned BONUS_COMBO   = DEF_BONUS_COMBO
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               beat_pulse,
  input  logic [LANES-1:0]   target_step,
  input  logic [LANES-1:0]   buttons,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [COMBO_W-1:0] max_combo,
  output logic               grade_valid,
  output logic [LANES-1:0]   grade_perfect,
  output logic [LANES-1:0]   grade_good,
  output logic [LANES-1:0]   grade_miss,
  output logic               green_led,
  output logic               red_led
);

  localparam int unsigned CNT_W = $clog2(LANES + 1);
  localparam int unsigned LED_W = $clog2(LED_HOLD + 1);
  localparam int unsigned PTS_W = SCORE_W + 1;
  localparam int unsigned CMB_W = COMBO_W + 1;

  if ((GOOD_TICKS <= PERFECT_TICKS) || (GOOD_TICKS >= (2 ** TICK_W) - 1)) begin : g_bad_window
    $error("GOOD_TICKS must exceed PERFECT_TICKS and fit below the tick counter limit");
  end
  if (BONUS_COMBO > (2 ** COMBO_W) - 1) begin : g_bad_bonus
    $error("BONUS_COMBO must be reachable by the combo counter");
  end

  logic [1:0]        state, state_nxt;
  logic [TICK_W-1:0] tick_cnt, tick_nxt;
  logic              close_c;
  grade_t            lane_grade [LANES];

  logic [CNT_W-1:0]   n_perf, n_good, n_miss, n_hit;
  logic [LANES-1:0]   perf_c, good_c, miss_c;
  logic [PTS_W-1:0]   pts_c, score_sum;
  logic [SCORE_W-1:0] score_nxt;
  logic [CMB_W-1:0]   combo_sum;
  logic [COMBO_W-1:0] combo_nxt, max_nxt;
  logic [LED_W-1:0]   green_cnt, red_cnt;

  // Window FSM: next state, tick counter and close strobe
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    close_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (beat_pulse) begin
          state_nxt = ST_OPEN;
          tick_nxt  = '0;
        end
      end
      ST_OPEN: begin
        if (beat_pulse) begin
          tick_nxt = '0;
        end else if (tick_cnt >= TICK_W'(GOOD_TICKS)) begin
          state_nxt = ST_CLOSED;
          tick_nxt  = TICK_W'(GOOD_TICKS + 1);
          close_c   = 1'b1;
        end else begin
          tick_nxt = tick_cnt + TICK_W'(1);
        end
      end
      ST_CLOSED: begin
        if (beat_pulse) begin
          state_nxt = ST_OPEN;
          tick_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        tick_nxt  = '0;
      end
    endcase
  end

  // FSM state and tick counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_grader #(
      .TICK_W       (TICK_W),
      .PERFECT_TICKS(PERFECT_TICKS)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .beat_pulse(beat_pulse),
      .close     (close_c),
      .state     (state),
      .tick_cnt  (tick_cnt),
      .target    (target_step[i]),
      .button    (buttons[i]),
      .grade_c   (lane_grade[i])
    );
  end

  // Per-lane flag masks and grade populations for this cycle
  always_comb begin
    perf_c = '0;
    good_c = '0;
    miss_c = '0;
    n_perf = '0;
    n_good = '0;
    n_miss = '0;
    for (int i = 0; i < LANES; i++) begin
      case (lane_grade[i])
        GRADE_PERFECT: begin perf_c[i] = 1'b1; n_perf = n_perf + CNT_W'(1); end
        GRADE_GOOD:    begin good_c[i] = 1'b1; n_good = n_good + CNT_W'(1); end
        GRADE_MISS:    begin miss_c[i] = 1'b1; n_miss = n_miss + CNT_W'(1); end
        default: ;
      endcase
    end
    n_hit = n_perf + n_good;
  end

  // Points, saturating score, combo and running maximum
  always_comb begin
    pts_c = PTS_W'(n_perf) * PTS_W'(PERFECT_PTS) + PTS_W'(n_good) * PTS_W'(GOOD_PTS);
`ifdef DDR_COMBO_BONUS_EN
    if (combo >= COMBO_W'(BONUS_COMBO)) begin
      pts_c = pts_c << 1;
    end
`endif
    score_sum = {1'b0, score} + pts_c;
    score_nxt = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    combo_sum = {1'b0, combo} + CMB_W'(n_hit);
    if (n_miss != '0) begin
      combo_nxt = '0;
    end else begin
      combo_nxt = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
    end
    max_nxt = (combo_nxt > max_combo) ? combo_nxt : max_combo;
  end

  // Registered grade flags, score and combo
  always_ff @(posedge clk) begin
    if (reset) begin
      grade_valid   <= 1'b0;
      grade_perfect <= '0;
      grade_good    <= '0;
      grade_miss    <= '0;
      score         <= '0;
      combo         <= '0;
      max_combo     <= '0;
    end else begin
      grade_valid   <= |(perf_c | good_c | miss_c);
      grade_perfect <= perf_c;
      grade_good    <= good_c;
      grade_miss    <= miss_c;
      score         <= score_nxt;
      combo         <= combo_nxt;
      max_combo     <= max_nxt;
    end
  end

  // LED hold timers; each event reloads its own counter
  always_ff @(posedge clk) begin
    if (reset) begin
      green_cnt <= '0;
      green_led <= 1'b0;
      red_cnt   <= '0;
      red_led   <= 1'b0;
    end else begin
      if (n_hit != '0) begin
        green_cnt <= LED_W'(LED_HOLD);
        green_led <= 1'b1;
      end else if (green_cnt != '0) begin
        green_cnt <= green_cnt - LED_W'(1);
        green_led <= (green_cnt != LED_W'(1));
      end else begin
        green_led <= 1'b0;
      end
      if (n_miss != '0) begin
        red_cnt <= LED_W'(LED_HOLD);
        red_led <= 1'b1;
      end else if (red_cnt != '0) begin
        red_cnt <= red_cnt - LED_W'(1);
        red_led <= (red_cnt != LED_W'(1));
      end else begin
        red_led <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddr_lane_judge.sv
// Bench for ddr_lane_judge: directed scenarios plus random play against a scoring model.
module tb_ddr_lane_judge;

  localparam int L    = 4;
  localparam int PERF = 8;
  localparam int GOOD = 20;
  localparam int HOLD = 1000;

  logic         clk = 1'b0;
  logic         reset;
  logic         beat_pulse;
  logic [L-1:0] target_step;
  logic [L-1:0] buttons;
  logic [31:0]  score;
  logic [7:0]   combo, max_combo;
  logic         grade_valid;
  logic [L-1:0] grade_perfect, grade_good, grade_miss;
  logic         green_led, red_led;

  int checks = 0;
  int errors = 0;

  ddr_lane_judge dut (
    .clk          (clk),
    .reset        (reset),
    .beat_pulse   (beat_pulse),
    .target_step  (target_step),
    .buttons      (buttons),
    .score        (score),
    .combo        (combo),
    .max_combo    (max_combo),
    .grade_valid  (grade_valid),
    .grade_perfect(grade_perfect),
    .grade_good   (grade_good),
    .grade_miss   (grade_miss),
    .green_led    (green_led),
    .red_led      (red_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Game model: window phase (0 none yet, 1 open, 2 closed), tick, targets still owed
  int          ph, tk;
  bit [L-1:0]  pend, prev_btn;
  longint      e_score;
  int          e_combo, e_max, g_left, r_left;
  bit [L-1:0]  e_perf, e_good, e_miss;
  bit          started = 0;

  always @(posedge clk) begin : model
    int     hits, misses;
    longint pts;
    bit     rise, closing;
    if (reset) begin
      ph = 0; tk = 0; pend = '0; prev_btn = '0;
      e_score = 0; e_combo = 0; e_max = 0; g_left = 0; r_left = 0;
      e_perf = '0; e_good = '0; e_miss = '0;
      started = 1;
    end else begin
      hits = 0; misses = 0; pts = 0;
      e_perf = '0; e_good = '0; e_miss = '0;
      closing = (ph == 1) && !beat_pulse && (tk + 1 > GOOD);
      for (int i = 0; i < L; i++) begin
        rise = buttons[i] && !prev_btn[i];
        if (ph != 0 && rise) begin
          if (pend[i] && tk <= PERF) begin e_perf[i] = 1; hits++; pts += 3; end
          else if (pend[i])          begin e_good[i] = 1; hits++; pts += 1; end
          else                       begin e_miss[i] = 1; misses++; end
          pend[i] = 0;
        end else if (pend[i] && (beat_pulse || closing)) begin
          e_miss[i] = 1; misses++; pend[i] = 0;
        end
      end
`ifdef DDR_COMBO_BONUS_EN
      if (e_combo >= 10) pts = pts * 2;
`endif
      e_score = (e_score + pts > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : e_score + pts;
      if (misses > 0) e_combo = 0;
      else e_combo = (e_combo + hits > 255) ? 255 : e_combo + hits;
      if (e_combo > e_max) e_max = e_combo;
      if (hits > 0) g_left = HOLD; else if (g_left > 0) g_left--;
      if (misses > 0) r_left = HOLD; else if (r_left > 0) r_left--;
      if (beat_pulse) begin ph = 1; tk = 0; pend = target_step; end
      else if (ph == 1) begin
        if (closing) begin ph = 2; tk = GOOD + 1; end
        else tk++;
      end
      prev_btn = buttons;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("m_score", score, e_score);
      chk("m_combo", combo, e_combo);
      chk("m_max", max_combo, e_max);
      chk("m_valid", grade_valid, |(e_perf | e_good | e_miss));
      chk("m_perf", grade_perfect, e_perf);
      chk("m_good", grade_good, e_good);
      chk("m_miss", grade_miss, e_miss);
      chk("m_green", green_led, g_left != 0);
      chk("m_red", red_led, r_left != 0);
    end
  end

  task automatic do_beat(input logic [L-1:0] t);
    beat_pulse = 1; target_step = t;
    @(negedge clk);
    beat_pulse = 0;
  endtask

  task automatic press(input logic [L-1:0] m);
    buttons = m;
    @(negedge clk);
    buttons = '0;
  endtask

  initial begin
    reset = 1; beat_pulse = 0; target_step = '0; buttons = '0;
    repeat (3) @(negedge clk);
    chk("rst_score", score, 0);
    chk("rst_combo", combo, 0);
    chk("rst_max", max_combo, 0);
    chk("rst_valid", grade_valid, 0);
    chk("rst_green", green_led, 0);
    chk("rst_red", red_led, 0);
    reset = 0;
    @(negedge clk);

    // Press before any beat is ignored
    press(4'b0001);
    chk("idle_valid", grade_valid, 0);
    chk("idle_score", score, 0);
    @(negedge clk);

    // PERFECT at tick 3, then green LED hold length
    do_beat(4'b0001);
    repeat (3) @(negedge clk);
    press(4'b0001);
    chk("s1_perf", grade_perfect, 4'b0001);
    chk("s1_score", score, 3);
    chk("s1_combo", combo, 1);
    chk("s1_green", green_led, 1);
    repeat (999) @(negedge clk);
    chk("s1_green_last", green_led, 1);
    @(negedge clk);
    chk("s1_green_off", green_led, 0);

    // Two lanes GOOD at tick 12
    do_beat(4'b0011);
    repeat (12) @(negedge clk);
    press(4'b0011);
    chk("s2_good", grade_good, 4'b0011);
    chk("s2_score", score, 5);
    chk("s2_combo", combo, 3);
    repeat (25) @(negedge clk);

    // Unpressed target misses at close
    do_beat(4'b0100);
    repeat (21) @(negedge clk);
    chk("s3_miss", grade_miss, 4'b0100);
    chk("s3_combo", combo, 0);
    chk("s3_red", red_led, 1);
    chk("s3_score", score, 5);
    chk("s3_max", max_combo, 3);

    // Stray press in closed window
    press(4'b1000);
    chk("s4_miss", grade_miss, 4'b1000);
    chk("s4_combo", combo, 0);

    // Beat coincident with a pending press at tick 15
    do_beat(4'b0001);
    repeat (15) @(negedge clk);
    beat_pulse = 1; target_step = 4'b0010; buttons = 4'b0001;
    @(negedge clk);
    beat_pulse = 0; buttons = '0;
    chk("s5_good", grade_good, 4'b0001);
    chk("s5_score", score, 6);
    repeat (2) @(negedge clk);
    press(4'b0010);
    chk("s5_perf", grade_perfect, 4'b0010);
    chk("s5_score2", score, 9);
    chk("s5_combo", combo, 2);

    // Reset mid-window discards pending and returns to idle
    do_beat(4'b0001);
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("s6_score", score, 0);
    chk("s6_combo", combo, 0);
    chk("s6_max", max_combo, 0);
    chk("s6_green", green_led, 0);
    press(4'b0001);
    chk("s6_valid", grade_valid, 0);
    chk("s6_score2", score, 0);

    // Eleven consecutive PERFECTs
    for (int k = 0; k < 11; k++) begin
      do_beat(4'b0001);
      press(4'b0001);
      if (k == 9) begin
        chk("s7_score10", score, 30);
        chk("s7_combo10", combo, 10);
      end
    end
`ifdef DDR_COMBO_BONUS_EN
    chk("s7_score11", score, 36);
`else
    chk("s7_score11", score, 33);
`endif
    chk("s7_combo11", combo, 11);

    // Random play
    for (int c = 0; c < 6000; c++) begin
      reset       = ($urandom_range(0, 999) == 0);
      beat_pulse  = !reset && ($urandom_range(0, 23) == 0);
      target_step = L'($urandom);
      for (int i = 0; i < L; i++)
        if ($urandom_range(0, 5) == 0) buttons[i] = ~buttons[i];
      @(negedge clk);
    end
    reset = 0; beat_pulse = 0; buttons = '0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
